// File: rtl/dot_product_accumulator.sv
// Sequential dot-product accumulate stage: exports the raw acc + term add to the
// external saturation stage and registers the saturated sum it returns as the new accumulator.
module dot_product_accumulator #(
    parameter int WIDTH_SUM = 4,
    parameter int LENGTH    = 3,
    parameter int CNT_W     = 2
) (
    input  logic                 clk_80,
    input  logic                 reset_80,
    input  logic                 start_80,
    input  logic                 in_valid_80,
    output logic                 in_ready_80,
    input  logic [WIDTH_SUM-1:0] term_80,
    output logic [WIDTH_SUM-1:0] sum_80,
    output logic                 carry_80,
    output logic                 oflow_80,
    input  logic [WIDTH_SUM-1:0] sum_saturated_80,
    output logic [WIDTH_SUM-1:0] result_80,
    output logic                 result_valid_80,
    input  logic                 result_ready_80,
    output logic                 busy_80,
    output logic [1:0]           dbg_state_80
);

    // Handshakes: a term transfers on a rising edge where in_valid_80 && in_ready_80;
    // a result transfers on a rising edge where result_valid_80 && result_ready_80.
    // Once raised, result_valid_80 and result_80 stay stable until that transfer.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LENGTH - 1);

    state_t               state;
    state_t               next_state;
    logic [WIDTH_SUM-1:0] acc;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH_SUM:0]   add_full;

    logic acc_clear;
    logic acc_load;
    logic result_load;
    logic valid_clear;

    // Raw add is always visible; the saturation stage decides what comes back.
    assign add_full = {1'b0, acc} + {1'b0, term_80};
    assign sum_80   = add_full[WIDTH_SUM-1:0];
    assign carry_80 = add_full[WIDTH_SUM];
    assign oflow_80 = (acc[WIDTH_SUM-1] == term_80[WIDTH_SUM-1]) &&
                      (sum_80[WIDTH_SUM-1] != acc[WIDTH_SUM-1]);

    always_ff @(posedge clk_80 or posedge reset_80) begin
        if (reset_80) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        acc_clear   = 1'b0;
        acc_load    = 1'b0;
        result_load = 1'b0;
        valid_clear = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_80) begin
                    acc_clear  = 1'b1;
                    next_state = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (in_valid_80) begin
                    acc_load = 1'b1;
                    if (cnt == LAST_CNT) begin
                        result_load = 1'b1;
                        next_state  = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                // A start alongside the result transfer chains straight into the next element.
                if (result_ready_80) begin
                    valid_clear = 1'b1;
                    if (start_80) begin
                        acc_clear  = 1'b1;
                        next_state = ST_ACCUM;
                    end else begin
                        next_state = ST_IDLE;
                    end
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_80 or posedge reset_80) begin
        if (reset_80) begin
            acc             <= '0;
            cnt             <= '0;
            result_80       <= '0;
            result_valid_80 <= 1'b0;
        end else begin
            if (acc_clear) begin
                acc <= '0;
                cnt <= '0;
            end else if (acc_load) begin
                acc <= sum_saturated_80;
                cnt <= cnt + 1'b1;
            end
            if (result_load) begin
                result_80       <= sum_saturated_80;
                result_valid_80 <= 1'b1;
            end else if (valid_clear) begin
                result_valid_80 <= 1'b0;
            end
        end
    end

    assign in_ready_80  = (state == ST_ACCUM);
    assign busy_80      = (state != ST_IDLE);
    assign dbg_state_80 = state;

endmodule

// File: doc/dot_product_accumulator.md
Name: dot_product_accumulator

Overview:
- Sequential accumulate stage directly upstream of the adder saturation stage in the matrix-multiply datapath.
- Accepts a stream of LENGTH signed product terms and exports the raw add of the accumulator and the current term (sum_80/carry_80/oflow_80) to the saturation stage.
- Registers the saturated value returned by that stage as the new accumulator.
- After LENGTH terms, presents one saturated dot-product element with a valid/ready handshake.

Parameters:
- WIDTH_SUM, 4, datapath width; two's complement, legal range -(2^(WIDTH_SUM-1)-1)..+(2^(WIDTH_SUM-1)-1).
- LENGTH, 3, terms per dot product; must be >= 1.
- CNT_W, 2, term-counter width; must satisfy 2^CNT_W >= LENGTH.

Ports:
- clk_80  input  1  clock; all state updates on rising edge.
- reset_80  input  1  asynchronous, active-high reset.
- start_80  input  1  begin a new dot product.
- in_valid_80  input  1  term_80 valid.
- in_ready_80  output  1  stage accepts a term this cycle.
- term_80  input  WIDTH_SUM  signed product term.
- sum_80  output  WIDTH_SUM  combinational low bits of acc + term_80, to the saturation stage.
- carry_80  output  1  combinational carry out of acc + term_80.
- oflow_80  output  1  combinational signed overflow of acc + term_80.
- sum_saturated_80  input  WIDTH_SUM  saturated sum returned by the saturation stage.
- result_80  output  WIDTH_SUM  registered dot-product result.
- result_valid_80  output  1  result_80 valid.
- result_ready_80  input  1  consumer accepts result_80.
- busy_80  output  1  high in ACCUM or HOLD.

Behaviour:
Reset:
- Asserting reset_80 forces, immediately: state=IDLE, acc=0, cnt=0, result_80=0, result_valid_80=0, in_ready_80=0, busy_80=0.
- Reset mid-ACCUM or mid-HOLD discards the partial or held result.

Adder (combinational, always active, any state):
- {carry_80, sum_80} = acc + term_80 as unsigned WIDTH_SUM+1-bit add.
- oflow_80 = (acc[MSB]==term_80[MSB]) && (sum_80[MSB]!=acc[MSB]).

States:
- IDLE: in_ready_80=0.
  - start_80=1 -> acc<=0, cnt<=0, go to ACCUM.
- ACCUM: in_ready_80=1.
  - in_valid_80=1 -> acc<=sum_saturated_80, cnt<=cnt+1.
  - If cnt==LENGTH-1 on that transfer: result_80<=sum_saturated_80, result_valid_80<=1, go to HOLD.
  - in_valid_80=0 -> hold all state.
  - start_80 is ignored in ACCUM.
- HOLD: in_ready_80=0; result_80 and result_valid_80 held stable until result_ready_80=1.
  - result_ready_80=1 -> result_valid_80<=0; next state is ACCUM (acc<=0, cnt<=0) if start_80=1 the same cycle, else IDLE.
  - start_80 without result_ready_80 is ignored.

Arithmetic and timing:
- Accumulation saturates per term, so the result is order dependent (non-associative); this is intended.
- term_80 = most-negative code (1000 for WIDTH_SUM=4) is accepted; the saturation stage corrects it to the minimum legal value.
- Latency: result_valid_80 rises on the clock edge that accepts the LENGTH-th term. Minimum LENGTH+1 cycles from start_80 to result_valid_80.
- Throughput: one term per cycle.

Test Plan:
1. WIDTH_SUM=4, LENGTH=3; start, then terms +2,+3,+1 back-to-back -> acc 2,5,6; result_80=0110, result_valid_80 on the 3rd accept edge.
2. Terms +5,+4,-2 -> 0101+0100 gives sum_80=1001, carry_80=0, oflow_80=1; acc saturates to 0111; 0111+1110 gives acc 0101; result_80=0101 (+5).
3. Terms -6,-5,0 -> 1010+1011 gives carry_80=1, oflow_80=1; acc=1001; result_80=1001 (-7).
4. First term 1000 -> sum_80=1000, no overflow; acc=1001; then +1,+1 -> result_80=1011 (-5).
5. Handshake and restart:
   - Gaps in in_valid_80 leave acc and cnt unchanged.
   - result_ready_80 held low 5 cycles -> result_80 stable, in_ready_80=0, start_80 ignored.
   - result_ready_80=1 with start_80=1 -> next cycle ACCUM with acc=0.
6. Reset asserted asynchronously after 2 terms -> all outputs 0 immediately; after release, a fresh start with +1,+1,+1 gives result_80=0011.
